// File: rtl/cnn_pkg.sv
// Shared types and width helpers for the MobileNet pointwise datapath.
// Default geometry targets a 56x56 plane with up to 1024 input channels.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WREQ,
        WLAT,
        RUN,
        FIN
    } pw_state_t;

    localparam int PW_DATA_W  = 8;
    localparam int PW_ACC_W   = 32;
    localparam int PW_MAX_PIX = 3136;
    localparam int PW_MAX_CH  = 1024;

    // Width of a counter that must be able to hold the value max_val itself.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // Width of an index into an array of the given depth.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int PW_PIX_W = cnt_w(PW_MAX_PIX);
    localparam int PW_CH_W  = cnt_w(PW_MAX_CH);

endpackage

// File: rtl/pw_acc_mem.sv
// Per-pixel partial-sum store: combinational read and one synchronous write,
// sharing a single address because each pixel is visited once per channel.
module pw_acc_mem
    import cnn_pkg::*;
#(
    parameter int ACC_W = PW_ACC_W,
    parameter int DEPTH = PW_MAX_PIX,
    parameter int AW    = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [ACC_W-1:0] i_wdata,
    output logic [ACC_W-1:0] o_rdata
);

    logic [ACC_W-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset; channel 0 overwrites every entry before
    // any later channel reads it, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/pointwise_acc_stage.sv
// 1x1 convolution accumulator for one output channel: reduces channel-planar
// int8 pixels against per-channel weights and streams raw ACC_W sums out.
module pointwise_acc_stage
    import cnn_pkg::*;
#(
    parameter  int DATA_W  = PW_DATA_W,
    parameter  int ACC_W   = PW_ACC_W,
    parameter  int MAX_PIX = PW_MAX_PIX,
    parameter  int MAX_CH  = PW_MAX_CH,
    localparam int PIX_W   = cnt_w(MAX_PIX),
    localparam int CH_W    = cnt_w(MAX_CH),
    localparam int WA_W    = idx_w(MAX_CH),
    localparam int MEM_AW  = idx_w(MAX_PIX)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [PIX_W-1:0]         cfg_num_pix,
    input  logic [CH_W-1:0]          cfg_in_ch,
    output logic                     busy,
    output logic                     done,
    output logic [WA_W-1:0]          wt_addr,
    input  logic signed [DATA_W-1:0] wt_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_acc
);

    pw_state_t                r_state;
    pw_state_t                w_state_nxt;
    logic [PIX_W-1:0]         r_num_pix;
    logic [CH_W-1:0]          r_in_ch;
    logic [PIX_W-1:0]         r_pix;
    logic [CH_W-1:0]          r_ch;
    logic signed [DATA_W-1:0] r_w_q;
    logic signed [ACC_W-1:0]  r_out_acc;
    logic                     r_out_valid;
    logic                     r_done;

    logic                     w_cfg_zero;
    logic                     w_first_ch;
    logic                     w_last_ch;
    logic                     w_last_pix;
    logic                     w_in_ready;
    logic                     w_in_fire;
    logic                     w_out_fire;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic [ACC_W-1:0]         w_mem_rd;
    logic [ACC_W-1:0]         w_sum;
    logic                     w_mem_we;

    assign w_cfg_zero = (cfg_num_pix == '0) || (cfg_in_ch == '0);
    assign w_first_ch = (r_ch == '0);
    assign w_last_ch  = (r_ch == r_in_ch - CH_W'(1));
    assign w_last_pix = (r_pix == r_num_pix - PIX_W'(1));

    // On the last channel the output register is only 1 deep, so input
    // acceptance follows its drain; earlier channels never touch it.
    assign w_in_ready = (r_state == RUN) && (!w_last_ch || !r_out_valid || out_ready);
    assign w_in_fire  = in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    assign w_prod     = in_data * r_w_q;
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_sum      = (w_first_ch ? '0 : w_mem_rd) + w_prod_ext;
    assign w_mem_we   = w_in_fire && !w_last_ch;

    pw_acc_mem #(
        .ACC_W (ACC_W),
        .DEPTH (MAX_PIX),
        .AW    (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (r_pix[MEM_AW-1:0]),
        .i_wdata (w_sum),
        .o_rdata (w_mem_rd)
    );

    // NOTE: the next-state value gets a default before the case statement so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_cfg_zero ? FIN : WREQ;
                end
            end
            WREQ: w_state_nxt = WLAT;
            WLAT: w_state_nxt = RUN;
            RUN: begin
                if (w_in_fire && w_last_pix) begin
                    w_state_nxt = w_last_ch ? FIN : WREQ;
                end
            end
            FIN: begin
                if (!r_out_valid || out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_num_pix   <= '0;
            r_in_ch     <= '0;
            r_pix       <= '0;
            r_ch        <= '0;
            r_w_q       <= '0;
            r_out_acc   <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == FIN) && (w_state_nxt == IDLE);

            if (r_state == IDLE && start) begin
                r_num_pix <= cfg_num_pix;
                r_in_ch   <= cfg_in_ch;
                r_pix     <= '0;
                r_ch      <= '0;
            end

            if (r_state == WLAT) begin
                r_w_q <= wt_data;
            end

            if (w_in_fire) begin
                if (w_last_pix) begin
                    r_pix <= '0;
                    r_ch  <= r_ch + CH_W'(1);
                end else begin
                    r_pix <= r_pix + PIX_W'(1);
                end
            end

            // A new result takes priority over draining the old one, so a
            // simultaneous in/out handshake leaves out_valid set with new data.
            if (w_in_fire && w_last_ch) begin
                r_out_acc   <= w_sum;
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign wt_addr   = r_ch[WA_W-1:0];
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;

endmodule

// File: tb/tb_pointwise_acc_stage.sv
// Self-checking bench for pointwise_acc_stage: table-driven passes checked
// against fixed vectors or a plain-arithmetic dot-product model.
module tb_pointwise_acc_stage;
    import cnn_pkg::*;

    localparam int DATA_W  = 8;
    localparam int ACC_W   = 32;
    localparam int MAX_PIX = 3136;
    localparam int MAX_CH  = 1024;
    localparam int PIX_W   = $clog2(MAX_PIX + 1);
    localparam int CH_W    = $clog2(MAX_CH + 1);
    localparam int WA_W    = $clog2(MAX_CH);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [PIX_W-1:0]         cfg_num_pix;
    logic [CH_W-1:0]          cfg_in_ch;
    logic                     busy, done, in_ready, out_valid;
    logic [WA_W-1:0]          wt_addr;
    logic signed [DATA_W-1:0] wt_data;
    logic                     in_valid, out_ready;
    logic signed [DATA_W-1:0] in_data;
    logic signed [ACC_W-1:0]  out_acc;

    logic                     busy16, done16, in_ready16, out_valid16;
    logic [WA_W-1:0]          wt_addr16;
    logic signed [DATA_W-1:0] wt_data16;
    logic signed [15:0]       out_acc16;

    int tests = 0;
    int fails = 0;

    logic signed [7:0]  wmem [MAX_CH];
    logic signed [7:0]  px[$];
    logic signed [31:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        wt_data   <= wmem[wt_addr];
        wt_data16 <= wmem[wt_addr16];
    end

    pointwise_acc_stage #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_PIX(MAX_PIX), .MAX_CH(MAX_CH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_pix(cfg_num_pix),
        .cfg_in_ch(cfg_in_ch), .busy(busy), .done(done), .wt_addr(wt_addr),
        .wt_data(wt_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc)
    );

    // Narrow-accumulator copy to observe modulo-2^16 wrap on the same stimulus.
    pointwise_acc_stage #(
        .DATA_W(DATA_W), .ACC_W(16), .MAX_PIX(MAX_PIX), .MAX_CH(MAX_CH)
    ) dut16 (
        .clk(clk), .rst(rst), .start(start), .cfg_num_pix(cfg_num_pix),
        .cfg_in_ch(cfg_in_ch), .busy(busy16), .done(done16), .wt_addr(wt_addr16),
        .wt_data(wt_data16), .in_valid(in_valid), .in_ready(in_ready16),
        .in_data(in_data), .out_valid(out_valid16), .out_ready(out_ready),
        .out_acc(out_acc16)
    );

    typedef struct {
        string name;
        int    np;
        int    nc;
        int    kind;      // 0 fixed table data, 1 all -128, 2 random + model
        int    out_mode;  // 0 always ready, 1 toggling, 2 random
        bit    gaps;
        bit    gap_chk;
        bit    mid_start;
        int    din[9];
        int    wv[3];
        int    ev[4];
    } vec_t;

    vec_t vt[10];

    task automatic check(input string nm, input logic signed [63:0] act,
                         input logic signed [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic load_vec(input vec_t v);
        longint s;
        px.delete();
        exp_q.delete();
        for (int c = 0; c < v.nc; c++) begin
            case (v.kind)
                0:       wmem[c] = 8'(v.wv[c]);
                1:       wmem[c] = -8'sd128;
                default: wmem[c] = 8'($urandom);
            endcase
        end
        for (int i = 0; i < v.np * v.nc; i++) begin
            case (v.kind)
                0:       px.push_back(8'(v.din[i]));
                1:       px.push_back(-8'sd128);
                default: px.push_back(8'($urandom));
            endcase
        end
        for (int p = 0; p < v.np && v.nc > 0; p++) begin
            if (v.kind == 2) begin
                s = 0;
                for (int c = 0; c < v.nc; c++) begin
                    s += longint'(px[c * v.np + p]) * longint'(wmem[c]);
                end
                exp_q.push_back(s[31:0]);
            end else begin
                exp_q.push_back(32'(v.ev[p]));
            end
        end
    endtask

    task automatic run_pass(input vec_t v);
        int total, idx, got, cyc, done_cyc, ndone, gaps_seen, low_run, budget;
        bit seen_ready, stalled, fin;
        logic signed [31:0] held;
        logic signed [15:0] e16;
        total = v.np * v.nc;
        idx = 0; got = 0; cyc = 0; done_cyc = -1; ndone = 0;
        gaps_seen = 0; low_run = 0; seen_ready = 0; stalled = 0; fin = 0;
        held = '0;
        budget = total * 8 + v.nc * 4 + 40;

        @(posedge clk); #1;
        start = 1'b1;
        cfg_num_pix = PIX_W'(v.np);
        cfg_in_ch = CH_W'(v.nc);
        in_valid = 1'b0;
        out_ready = 1'b1;

        while (!fin) begin
            @(posedge clk); #1;
            cyc++;
            start = v.mid_start && (cyc == 6);
            cfg_num_pix = PIX_W'($urandom);
            cfg_in_ch = CH_W'($urandom);
            in_valid = (idx < total) && (!v.gaps || ($urandom_range(0, 2) != 0));
            in_data = (idx < total) ? px[idx] : '0;
            case (v.out_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase

            @(negedge clk);
            if (cyc == 1) check({v.name, " busy_after_start"}, busy, 1);
            if (in_valid && in_ready) idx++;

            if (stalled) begin
                check({v.name, " hold_valid"}, out_valid, 1);
                check({v.name, " hold_acc"}, out_acc, held);
            end
            stalled = out_valid && !out_ready;
            held = out_acc;

            if (out_valid && out_ready) begin
                if (got < exp_q.size()) begin
                    e16 = exp_q[got][15:0];
                    check({v.name, " out_acc"}, out_acc, exp_q[got]);
                    check({v.name, " out_valid16"}, out_valid16, 1);
                    check({v.name, " out_acc16"}, out_acc16, e16);
                end else begin
                    check({v.name, " extra_output"}, got + 1, exp_q.size());
                end
                got++;
            end

            if (in_ready) begin
                if (seen_ready && low_run > 0) begin
                    if (v.gap_chk) check({v.name, " plane_gap"}, low_run, 2);
                    gaps_seen++;
                end
                low_run = 0;
                seen_ready = 1'b1;
            end else if (seen_ready) begin
                low_run++;
            end

            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    done_cyc = cyc;
                    check({v.name, " busy_at_done"}, busy, 0);
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) fin = 1'b1;
            if (cyc > budget) begin
                check({v.name, " timeout"}, cyc, budget);
                fin = 1'b1;
            end
        end

        in_valid = 1'b0;
        check({v.name, " done_count"}, ndone, 1);
        check({v.name, " outputs"}, got, exp_q.size());
        check({v.name, " consumed"}, idx, total);
        check({v.name, " in_ready_seen"}, seen_ready, (total > 0));
        if (v.gap_chk) check({v.name, " plane_gaps"}, gaps_seen, (v.nc > 0) ? v.nc - 1 : 0);
        if (total == 0) check({v.name, " done_latency"}, done_cyc, 2);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ov_seen;
        vt[0] = '{name:"c1_single_ch", np:4, nc:1, kind:0, out_mode:0, gaps:0, gap_chk:1,
                  mid_start:0, din:'{1, -2, 127, -128, 0, 0, 0, 0, 0}, wv:'{3, 0, 0},
                  ev:'{3, -6, 381, -384}};
        vt[1] = '{name:"c2_three_ch", np:3, nc:3, kind:0, out_mode:0, gaps:0, gap_chk:1,
                  mid_start:0, din:'{1, 2, 3, 4, 5, 6, -1, 0, 1}, wv:'{2, -1, 5},
                  ev:'{-7, -1, 5, 0}};
        vt[2] = '{name:"c3_stalls", np:3, nc:3, kind:0, out_mode:1, gaps:1, gap_chk:0,
                  mid_start:0, din:'{1, 2, 3, 4, 5, 6, -1, 0, 1}, wv:'{2, -1, 5},
                  ev:'{-7, -1, 5, 0}};
        vt[3] = '{name:"c4_max_ch", np:2, nc:MAX_CH, kind:1, out_mode:0, gaps:0, gap_chk:1,
                  mid_start:0, din:'{default:0}, wv:'{default:0},
                  ev:'{16777216, 16777216, 0, 0}};
        vt[4] = '{name:"c5_zero_pix", np:0, nc:5, kind:0, out_mode:0, gaps:0, gap_chk:0,
                  mid_start:0, din:'{default:0}, wv:'{default:0}, ev:'{default:0}};
        vt[5] = '{name:"c5_zero_ch", np:3, nc:0, kind:0, out_mode:0, gaps:0, gap_chk:0,
                  mid_start:0, din:'{default:0}, wv:'{default:0}, ev:'{default:0}};
        vt[6] = '{name:"c5_mid_start", np:3, nc:3, kind:0, out_mode:2, gaps:0, gap_chk:0,
                  mid_start:1, din:'{1, 2, 3, 4, 5, 6, -1, 0, 1}, wv:'{2, -1, 5},
                  ev:'{-7, -1, 5, 0}};
        vt[7] = '{name:"rand_a", np:5, nc:4, kind:2, out_mode:2, gaps:1, gap_chk:0,
                  mid_start:0, din:'{default:0}, wv:'{default:0}, ev:'{default:0}};
        vt[8] = '{name:"rand_b", np:7, nc:1, kind:2, out_mode:2, gaps:1, gap_chk:0,
                  mid_start:1, din:'{default:0}, wv:'{default:0}, ev:'{default:0}};
        vt[9] = '{name:"rand_c", np:1, nc:6, kind:2, out_mode:1, gaps:1, gap_chk:0,
                  mid_start:0, din:'{default:0}, wv:'{default:0}, ev:'{default:0}};

        for (int c = 0; c < MAX_CH; c++) wmem[c] = '0;
        rst = 1'b1; start = 1'b0; cfg_num_pix = '0; cfg_in_ch = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_acc", out_acc, 0);
        check("reset wt_addr", wt_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            load_vec(vt[i]);
            run_pass(vt[i]);
        end

        // Reset while a result is parked in the output register.
        load_vec(vt[0]);
        @(posedge clk); #1;
        start = 1'b1; cfg_num_pix = PIX_W'(4); cfg_in_ch = CH_W'(1);
        out_ready = 1'b0; in_valid = 1'b0;
        ov_seen = 1'b0;
        for (int k = 0; k < 20 && !ov_seen; k++) begin
            @(posedge clk); #1;
            start = 1'b0; in_valid = 1'b1; in_data = px[0];
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
        end
        check("rst_mid out_valid_before", ov_seen, 1);
        check("rst_mid out_acc_before", out_acc, 3);
        #2 rst = 1'b1;
        #1;
        check("rst_mid out_valid", out_valid, 0);
        check("rst_mid out_valid16", out_valid16, 0);
        check("rst_mid busy", busy, 0);
        check("rst_mid done", done, 0);
        check("rst_mid in_ready", in_ready, 0);
        check("rst_mid out_acc", out_acc, 0);
        check("rst_mid wt_addr", wt_addr, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        load_vec(vt[0]);
        run_pass(vt[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
